// File: rtl/simon_input_conditioner_if.sv
// Raw pushbutton/switch inputs and conditioned outputs of the Simon Says input front end.
interface simon_input_conditioner_if;
   logic       key_submit_n;
   logic       key_start_round_n;
   logic [2:0] sw_guess;
   logic       sw_start;
   logic       sw_initialize;
   logic [1:0] sw_difficulty;
   logic       submit;
   logic       startRound;
   logic       submit_press;
   logic       submit_release;
   logic       start_round_press;
   logic [2:0] userGuess;
   logic       start;
   logic       initialize;
   logic [1:0] difficulty;

   modport master (
      output key_submit_n, key_start_round_n, sw_guess, sw_start, sw_initialize, sw_difficulty,
      input  submit, startRound, submit_press, submit_release, start_round_press,
             userGuess, start, initialize, difficulty
   );

   modport slave (
      input  key_submit_n, key_start_round_n, sw_guess, sw_start, sw_initialize, sw_difficulty,
      output submit, startRound, submit_press, submit_release, start_round_press,
             userGuess, start, initialize, difficulty
   );
endinterface

// File: rtl/simon_input_conditioner.sv
// Synchronises and debounces KEY0/KEY3, synchronises the slide switches and
// latches the colour guess on every debounced submit press.
module simon_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic                     clk,
   input  logic                     rst,
   simon_input_conditioner_if.slave bus
);

   typedef enum logic [1:0] {UP, CNT_DN, DOWN, CNT_UP} key_state_t;

   localparam int unsigned      NKEYS    = 2;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Key index 0 is KEY0 (submit), index 1 is KEY3 (startRound).
   logic [NKEYS-1:0] key_s1, key_s2;
   // Switch bits: [2:0] guess, [3] start, [4] initialize, [6:5] difficulty.
   logic [6:0]       sw_s1, sw_s2;

   key_state_t       state_q [NKEYS];
   key_state_t       state_d [NKEYS];
   logic [CNT_W-1:0] cnt_q   [NKEYS];
   logic [CNT_W-1:0] cnt_d   [NKEYS];
   logic [NKEYS-1:0] level_q, level_d;
   logic [NKEYS-1:0] press_q, press_d;
   logic             release_q, release_d;
   logic [2:0]       guess_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_s1 <= '1;
         key_s2 <= '1;
         sw_s1  <= '0;
         sw_s2  <= '0;
      end else begin
         key_s1 <= {bus.key_start_round_n, bus.key_submit_n};
         key_s2 <= key_s1;
         sw_s1  <= {bus.sw_difficulty, bus.sw_initialize, bus.sw_start, bus.sw_guess};
         sw_s2  <= sw_s1;
      end
   end

   // A reversion of s2 while counting always wins over reaching the last count.
   always_comb begin
      release_d = 1'b0;
      for (int unsigned k = 0; k < NKEYS; k++) begin
         state_d[k] = state_q[k];
         cnt_d[k]   = cnt_q[k];
         level_d[k] = level_q[k];
         press_d[k] = 1'b0;
         unique case (state_q[k])
            UP: begin
               if (!key_s2[k]) begin
                  state_d[k] = CNT_DN;
                  cnt_d[k]   = '0;
               end
            end
            CNT_DN: begin
               if (key_s2[k]) begin
                  state_d[k] = UP;
               end else if (cnt_q[k] == CNT_LAST) begin
                  state_d[k] = DOWN;
                  level_d[k] = 1'b0;
                  press_d[k] = 1'b1;
               end else begin
                  cnt_d[k] = cnt_q[k] + 1'b1;
               end
            end
            DOWN: begin
               if (key_s2[k]) begin
                  state_d[k] = CNT_UP;
                  cnt_d[k]   = '0;
               end
            end
            CNT_UP: begin
               if (!key_s2[k]) begin
                  state_d[k] = DOWN;
               end else if (cnt_q[k] == CNT_LAST) begin
                  state_d[k] = UP;
                  level_d[k] = 1'b1;
                  if (k == 0) release_d = 1'b1;
               end else begin
                  cnt_d[k] = cnt_q[k] + 1'b1;
               end
            end
            default: state_d[k] = UP;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned k = 0; k < NKEYS; k++) begin
            state_q[k] <= UP;
            cnt_q[k]   <= '0;
         end
         level_q   <= '1;
         press_q   <= '0;
         release_q <= 1'b0;
         guess_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         if (press_d[0]) guess_q <= sw_s2[2:0];
      end
   end

   assign bus.submit            = level_q[0];
   assign bus.startRound        = level_q[1];
   assign bus.submit_press      = press_q[0];
   assign bus.submit_release    = release_q;
   assign bus.start_round_press = press_q[1];
   assign bus.userGuess         = guess_q;
   assign bus.start             = sw_s2[3];
   assign bus.initialize        = sw_s2[4];
   assign bus.difficulty        = sw_s2[6:5];

endmodule

// File: tb/tb_simon_input_conditioner.sv
// Randomised and directed bench for simon_input_conditioner against a run-length
// model: a key level flips after DB+1 consecutive synchronised samples disagree with it.
module tb_simon_input_conditioner;

   localparam int DB = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;

   simon_input_conditioner_if bus();

   simon_input_conditioner #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int edge_n = 0;

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state
   logic [1:0] m_kh1, m_kh2, m_level, m_press, seen;
   logic       m_rel;
   int         m_run [2];
   logic [6:0] m_swh1, m_swh2, m_swout;
   logic [2:0] m_guess;

   // Events observed on the DUT, for the directed latency/count checks
   int sp_cnt = 0, sp_edge = 0, rel_cnt = 0, rel_edge = 0, srp_cnt = 0, sr_low = 0;

   always @(negedge clk) begin
      if (!rst) begin
         m_kh1 = '1; m_kh2 = '1; m_level = '1; m_press = '0; m_rel = 1'b0;
         m_run[0] = 0; m_run[1] = 0;
         m_swh1 = '0; m_swh2 = '0; m_swout = '0; m_guess = '0;
      end else begin
         seen  = m_kh2;
         m_kh2 = m_kh1;
         m_kh1 = {bus.key_start_round_n, bus.key_submit_n};
         m_press = '0;
         m_rel   = 1'b0;
         for (int k = 0; k < 2; k++) begin
            if (seen[k] != m_level[k]) m_run[k]++;
            else m_run[k] = 0;
            if (m_run[k] == DB + 1) begin
               m_level[k] = seen[k];
               m_run[k]   = 0;
               if (!seen[k]) m_press[k] = 1'b1;
               else if (k == 0) m_rel = 1'b1;
            end
         end
         if (m_press[0]) m_guess = m_swh2[2:0];
         m_swout = m_swh1;
         m_swh2  = m_swh1;
         m_swh1  = {bus.sw_difficulty, bus.sw_initialize, bus.sw_start, bus.sw_guess};
      end
      check("submit",            32'(bus.submit),            32'(m_level[0]));
      check("startRound",        32'(bus.startRound),        32'(m_level[1]));
      check("submit_press",      32'(bus.submit_press),      32'(m_press[0]));
      check("submit_release",    32'(bus.submit_release),    32'(m_rel));
      check("start_round_press", 32'(bus.start_round_press), 32'(m_press[1]));
      check("userGuess",         32'(bus.userGuess),         32'(m_guess));
      check("start",             32'(bus.start),             32'(m_swout[3]));
      check("initialize",        32'(bus.initialize),        32'(m_swout[4]));
      check("difficulty",        32'(bus.difficulty),        32'(m_swout[6:5]));
      if (bus.submit_press === 1'b1) begin sp_cnt++; sp_edge = edge_n; end
      if (bus.submit_release === 1'b1) begin rel_cnt++; rel_edge = edge_n; end
      if (bus.start_round_press === 1'b1) srp_cnt++;
      if (bus.startRound !== 1'b1) sr_low++;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   int t0, c0, h0;
   int hold [2];
   logic [1:0] kv;

   initial begin
      // 1: reset with keys pressed and every switch high
      bus.key_submit_n = 1'b0; bus.key_start_round_n = 1'b0;
      bus.sw_guess = '1; bus.sw_start = 1'b1; bus.sw_initialize = 1'b1; bus.sw_difficulty = '1;
      tick(3);
      check("rst_submit",      32'(bus.submit),            32'd1);
      check("rst_startRound",  32'(bus.startRound),        32'd1);
      check("rst_pulses",      32'({bus.submit_press, bus.submit_release, bus.start_round_press}), 32'd0);
      check("rst_userGuess",   32'(bus.userGuess),         32'd0);
      check("rst_start",       32'(bus.start),             32'd0);
      check("rst_initialize",  32'(bus.initialize),        32'd0);
      check("rst_difficulty",  32'(bus.difficulty),        32'd0);
      bus.key_submit_n = 1'b1; bus.key_start_round_n = 1'b1;
      bus.sw_guess = '0; bus.sw_start = 1'b0; bus.sw_initialize = 1'b0; bus.sw_difficulty = '0;
      rst = 1'b1;
      tick(4);

      // 2: clean press then clean release
      t0 = edge_n; c0 = sp_cnt;
      bus.key_submit_n = 1'b0;
      tick(12);
      check("t2_press_count",   32'(sp_cnt - c0),  32'd1);
      check("t2_press_edge",    32'(sp_edge - t0), 32'd7);
      t0 = edge_n; c0 = rel_cnt;
      bus.key_submit_n = 1'b1;
      tick(12);
      check("t2_release_count", 32'(rel_cnt - c0),  32'd1);
      check("t2_release_edge",  32'(rel_edge - t0), 32'd7);

      // 3: bouncy press
      c0 = sp_cnt;
      bus.key_submit_n = 1'b0; tick(2);
      bus.key_submit_n = 1'b1; tick(1);
      bus.key_submit_n = 1'b0; tick(2);
      bus.key_submit_n = 1'b1; tick(1);
      t0 = edge_n;
      bus.key_submit_n = 1'b0; tick(12);
      check("t3_press_count", 32'(sp_cnt - c0),  32'd1);
      check("t3_press_edge",  32'(sp_edge - t0), 32'd7);
      bus.key_submit_n = 1'b1; tick(12);

      // 4: short startRound glitch is rejected
      c0 = srp_cnt; h0 = sr_low;
      bus.key_start_round_n = 1'b0; tick(3);
      bus.key_start_round_n = 1'b1; tick(12);
      check("t4_no_press", 32'(srp_cnt - c0), 32'd0);
      check("t4_level_1",  32'(sr_low - h0),  32'd0);

      // 5: guess latched only on the press
      bus.sw_guess = 3'b011; tick(3);
      bus.key_submit_n = 1'b0; tick(9);
      bus.sw_guess = 3'b100; tick(3);
      bus.key_submit_n = 1'b1; tick(12);
      check("t5_guess_held", 32'(bus.userGuess), 32'h3);
      bus.key_submit_n = 1'b0; tick(12);
      check("t5_guess_new",  32'(bus.userGuess), 32'h4);
      bus.key_submit_n = 1'b1; tick(12);

      // 6: reset mid-count restarts qualification
      bus.key_submit_n = 1'b0; tick(5);
      rst = 1'b0; tick(1);
      c0 = sp_cnt;
      rst = 1'b1; t0 = edge_n;
      tick(12);
      check("t6_press_count", 32'(sp_cnt - c0),  32'd1);
      check("t6_press_edge",  32'(sp_edge - t0), 32'd7);
      bus.key_submit_n = 1'b1; tick(12);

      // Randomised phase: bouncy keys, wandering switches, occasional resets
      kv = 2'b11; hold[0] = 0; hold[1] = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < 2; k++) begin
            if (hold[k] == 0) begin
               kv[k]   = ~kv[k];
               hold[k] = $urandom_range(1, 10);
            end else begin
               hold[k]--;
            end
         end
         bus.key_submit_n      = kv[0];
         bus.key_start_round_n = kv[1];
         if ($urandom_range(0, 3) == 0) begin
            bus.sw_guess      = 3'($urandom_range(0, 7));
            bus.sw_start      = 1'($urandom_range(0, 1));
            bus.sw_initialize = 1'($urandom_range(0, 1));
            bus.sw_difficulty = 2'($urandom_range(0, 3));
         end
         rst = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
         tick(1);
      end
      rst = 1'b1;
      bus.key_submit_n = 1'b1; bus.key_start_round_n = 1'b1;
      tick(12);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
